btb_predictor: RTL
==================

Name: btb_predictor

Overview:
- Address-stage branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Produces the per-fetch prediction bundle consumed by the AD/fetch pipeline register: target, branch flag, looked-up PC, prior counter, prior hit.
- Accepts resolved-branch feedback carrying that same bundle back from execute and trains the table.
- Includes a sequenced invalidate-all operation for context switches.

Parameters:
INDEX_BITS, 4, log2 of entry count (ENTRIES = 2**INDEX_BITS)
PC_W, 32, PC/target width

Ports:
stg_clk  in  1  clock
reset  in  1  synchronous active-high reset
stg_ena  in  1  stage enable; lookup outputs update only when high
stg_x  in  1  stage squash; next registered bundle is forced to "no prediction"
pc_fetch  in  PC_W  PC being fetched, looked up this cycle
upd_valid  in  1  resolved branch feedback valid (single cycle)
upd_pc  in  PC_W  PC of the resolved branch (returned pc_fetch_update)
upd_taken  in  1  actual outcome
upd_target  in  PC_W  actual target
upd_prev_counter  in  2  counter returned with the bundle
upd_prev_valid  in  1  hit flag returned with the bundle
inv_all  in  1  request invalidation of all entries (pulse)
busy  out  1  high while invalidation runs
pc_target_ad  out  PC_W  predicted target
flag_branch_ad  out  2  00 no entry, 01 hit predict not-taken, 10 hit predict taken, 11 never driven
pc_fetch_update  out  PC_W  registered copy of pc_fetch
prev_counter  out  2  counter read at lookup (00 on miss)
prev_valid  out  1  1 on BTB hit

Behaviour:
- Indexing: index = pc[INDEX_BITS+1:2]; tag = pc[PC_W-1:INDEX_BITS+2]; pc[1:0] ignored.
- Entry contents: valid bit, tag, target, 2-bit counter (00 SN, 01 WN, 10 WT, 11 ST).
- Reset (synchronous): all valid bits cleared in one cycle; all outputs 0; busy 0; FSM to IDLE. Update presented in the reset cycle is dropped.
- Lookup, latency 1:
  - On the stg_clk edge with stg_ena=1, register pc_fetch_update=pc_fetch.
  - Hit (valid and tag match): prev_valid=1, prev_counter=counter, pc_target_ad=target, flag_branch_ad = counter[1] ? 10 : 01.
  - Miss: prev_valid=0, prev_counter=00, pc_target_ad=0, flag_branch_ad=00.
  - stg_ena=0: all outputs hold.
  - stg_x=1 with stg_ena=1: outputs loaded as a miss; pc_fetch_update still loads pc_fetch. stg_x is ignored when stg_ena=0.
- Update, applied on the edge where upd_valid=1 (independent of stg_ena):
  - upd_prev_valid=1: counter = saturating inc (taken) or dec (not taken) of upd_prev_counter. Also write tag, target=upd_target, and valid=1. No wrap: 11+inc=11, 00+dec=00.
  - upd_prev_valid=0 and taken: allocate/overwrite entry; counter=10, valid=1.
  - upd_prev_valid=0 and not taken: no write.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (read-before-write, no bypass). The update takes effect for lookups on the following cycles.
- FSM IDLE/CLEAR:
  - inv_all in IDLE -> CLEAR with clr_idx=0. Each cycle, clear valid[clr_idx] and increment clr_idx.
  - Leave CLEAR after entry ENTRIES-1, so busy is high for exactly ENTRIES cycles.
  - During CLEAR: lookups report miss, updates are dropped, inv_all is ignored.
  - reset during CLEAR -> IDLE with all entries invalid.

Test Plan:
- Reset, then look up 0x0000_0040 -> next cycle flag 00, prev_valid 0, prev_counter 00, pc_fetch_update 0x40.
- Update pc=0x40 taken target=0x100, prev_valid=0; then look up 0x40 -> flag 10, target 0x100, prev_counter 10, prev_valid 1.
- Feed four not-taken updates with returned counters 10,01,00,00 -> stored counters 01,00,00,00. A lookup after the second update gives flag 01; four taken updates from 00 saturate at 11.
- Alias: pc 0x40 then 0x80 with INDEX_BITS=4 (same index, different tag), allocate 0x80 taken -> lookup 0x40 misses (flag 00).
- Same-cycle lookup and allocate of 0x200 -> that lookup misses; the next-cycle lookup hits. stg_ena=0 holds outputs; stg_x forces flag 00.
- Fill 3 entries, pulse inv_all -> busy high for 16 cycles; lookups and updates during CLEAR give miss/no effect; afterward all lookups miss. Reset at CLEAR cycle 5 -> busy 0 next cycle.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Registered per-fetch prediction bundle, branch-resolution training, sequenced invalidate-all.
module btb_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned PC_W       = 32
) (
  input  logic            stg_clk,
  input  logic            reset,
  input  logic            stg_ena,
  input  logic            stg_x,
  input  logic [PC_W-1:0] pc_fetch,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic [1:0]      upd_prev_counter,
  input  logic            upd_prev_valid,
  input  logic            inv_all,
  output logic            busy,
  output logic [PC_W-1:0] pc_target_ad,
  output logic [1:0]      flag_branch_ad,
  output logic [PC_W-1:0] pc_fetch_update,
  output logic [1:0]      prev_counter,
  output logic            prev_valid
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = PC_W - INDEX_BITS - 2;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic                    clr_en;

  logic [ENTRIES-1:0]      valid_q;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [PC_W-1:0]         tgt_q [ENTRIES];
  logic [1:0]              ctr_q [ENTRIES];

  logic [PC_W-1:0]         pc_target_q, pc_target_d;
  logic [1:0]              flag_q, flag_d;
  logic [PC_W-1:0]         pcu_q;
  logic [1:0]              pctr_q, pctr_d;
  logic                    pvld_q, pvld_d;

  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]        lk_tag, up_tag;
  logic                    lk_hit;
  logic                    wr_en;
  logic [1:0]              wr_ctr;
  logic                    unused_pc_lsb;

  assign lk_idx = pc_fetch[INDEX_BITS+1:2];
  assign lk_tag = pc_fetch[PC_W-1:INDEX_BITS+2];
  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign up_tag = upd_pc[PC_W-1:INDEX_BITS+2];
  assign unused_pc_lsb = ^upd_pc[1:0];

  // Invalidate-all sequencer: one entry per cycle.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inv_all) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_en    = 1'b1;
        clr_idx_d = clr_idx_q + INDEX_BITS'(1);
        if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge stg_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Lookup reads pre-update table contents; squash or clearing forces a miss.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !stg_x && (state_q == ST_IDLE);
    pc_target_d = '0;
    flag_d      = 2'b00;
    pctr_d      = 2'b00;
    pvld_d      = 1'b0;
    if (lk_hit) begin
      pc_target_d = tgt_q[lk_idx];
      flag_d      = ctr_q[lk_idx][1] ? 2'b10 : 2'b01;
      pctr_d      = ctr_q[lk_idx];
      pvld_d      = 1'b1;
    end
  end

  always_ff @(posedge stg_clk) begin
    if (reset) begin
      pc_target_q <= '0;
      flag_q      <= 2'b00;
      pcu_q       <= '0;
      pctr_q      <= 2'b00;
      pvld_q      <= 1'b0;
    end else if (stg_ena) begin
      pc_target_q <= pc_target_d;
      flag_q      <= flag_d;
      pcu_q       <= pc_fetch;
      pctr_q      <= pctr_d;
      pvld_q      <= pvld_d;
    end
  end

  // Training: saturating step on a returned hit, allocate weakly-taken on a taken miss.
  always_comb begin
    wr_en  = upd_valid && !reset && (state_q == ST_IDLE) && (upd_prev_valid || upd_taken);
    wr_ctr = 2'b10;
    if (upd_prev_valid) begin
      if (upd_taken) wr_ctr = (upd_prev_counter == 2'b11) ? 2'b11 : upd_prev_counter + 2'd1;
      else           wr_ctr = (upd_prev_counter == 2'b00) ? 2'b00 : upd_prev_counter - 2'd1;
    end
  end

  always_ff @(posedge stg_clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx_q] <= 1'b0;
      if (wr_en)  valid_q[up_idx]    <= 1'b1;
    end
  end

  always_ff @(posedge stg_clk) begin
    if (wr_en) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
      ctr_q[up_idx] <= wr_ctr;
    end
  end

  assign busy            = (state_q == ST_CLEAR);
  assign pc_target_ad    = pc_target_q;
  assign flag_branch_ad  = flag_q;
  assign pc_fetch_update = pcu_q;
  assign prev_counter    = pctr_q;
  assign prev_valid      = pvld_q;

endmodule
